// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: round-robin GREEN->YELLOW->ALLRED scheduler for a 4-approach intersection.
// Optional emergency preemption (preempt/preempt_id ports) is built when TLC_PREEMPT_EN is defined.
module tlc_phase_scheduler #(
  parameter int         N_APPR  = 4,
  parameter int         TW      = 8,
  parameter logic [1:0] HOME_ID = 2'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  tick,
  input  logic [N_APPR-1:0]     req,
`ifdef TLC_PREEMPT_EN
  input  logic                  preempt,
  input  logic [1:0]            preempt_id,
`endif
  input  logic [TW-1:0]         green_ticks,
  input  logic [TW-1:0]         yel_ticks,
  input  logic [TW-1:0]         allred_ticks,
  output logic [3*N_APPR-1:0]   lights,
  output logic [1:0]            active_id,
  output logic [1:0]            phase,
  output logic [N_APPR-1:0]     pending
);
  typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, ALLRED = 2'b10} phase_t;
  localparam logic [11:0] L_HOME = (12'o4444 & ~(12'o7 << 3*HOME_ID)) | (12'o1 << 3*HOME_ID);
  phase_t phase_q, phase_d;
  logic [1:0] active_q, active_d, target_q, target_d, sel, pre_id;
  logic [TW-1:0] timer_q, timer_d, dur_q, dur_d;
  logic [N_APPR-1:0] pending_q, pending_d, others, green_mask;
  logic [11:0] lights_q, lights_d;
  logic step, done, enter, pre_go, pre_hold, retarget;

  function automatic logic [TW-1:0] clamp(input logic [TW-1:0] d);
    return d == '0 ? TW'(1) : d;
  endfunction

`ifdef TLC_PREEMPT_EN
  assign pre_id   = preempt_id;
  assign pre_go   = preempt && phase_q == GREEN && active_q != preempt_id;
  assign pre_hold = preempt && phase_q == GREEN && active_q == preempt_id;
  assign retarget = preempt && phase_q != GREEN;
`else
  assign pre_id   = 2'd0;
  assign pre_go   = 1'b0;
  assign pre_hold = 1'b0;
  assign retarget = 1'b0;
`endif

  // Timer saturates at the sampled duration so an extended green stays expired.
  assign step       = ena && tick && timer_q != dur_q;
  assign done       = timer_q == dur_q || (step && timer_q + TW'(1) == dur_q);
  assign others     = pending_q & ~(4'b1 << active_q);
  assign green_mask = phase_q == GREEN ? 4'b1 << active_q : 4'b0;

  always_comb begin
    sel = HOME_ID;
    for (int i = 3; i >= 1; i--) if (others[active_q + 2'(i)]) sel = active_q + 2'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= GREEN;
      active_q  <= HOME_ID;
      target_q  <= HOME_ID;
      timer_q   <= '0;
      dur_q     <= clamp(green_ticks);
      pending_q <= '0;
      lights_q  <= L_HOME;
    end else begin
      phase_q   <= phase_d;
      active_q  <= active_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      dur_q     <= dur_d;
      pending_q <= pending_d;
      lights_q  <= lights_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    target_d = retarget ? pre_id : target_q;
    if (ena) begin
      if (phase_q == GREEN) begin
        if (pre_go) begin
          phase_d  = YELLOW;
          target_d = pre_id;
        end else if (!pre_hold && done && (|others || active_q != HOME_ID)) begin
          phase_d  = YELLOW;
          target_d = sel;
        end
      end else if (done) begin
        phase_d  = phase_q == YELLOW ? ALLRED : GREEN;
        active_d = phase_q == YELLOW ? active_q : target_d;
      end
    end
    enter     = phase_d != phase_q;
    timer_d   = enter ? '0 : step ? timer_q + TW'(1) : timer_q;
    dur_d     = enter ? clamp(phase_d == GREEN ? green_ticks : phase_d == YELLOW ? yel_ticks : allred_ticks) : dur_q;
    // A request arriving on the edge its approach turns green is already being served.
    pending_d = (pending_q | (req & ~green_mask)) & ~(enter && phase_d == GREEN ? 4'b1 << active_d : 4'b0);
  end

  always_comb begin
    lights_d = {4{3'b100}};
    if (phase_d != ALLRED) lights_d[3*active_d +: 3] = phase_d == GREEN ? 3'b001 : 3'b010;
  end

  assign lights    = lights_q;
  assign active_id = active_q;
  assign phase     = phase_q;
  assign pending   = pending_q;
endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb_tlc_phase_scheduler: vector table plus directed multi-cycle sequences for tlc_phase_scheduler.
module tb_tlc_phase_scheduler;
  logic clk = 0, rst_n = 0, ena = 1, tick = 0;
  logic [3:0] req = '0;
  logic [7:0] gt = 8'd2, yt = 8'd1, at = 8'd1;
  logic [11:0] lights;
  logic [1:0] active_id, phase;
  logic [3:0] pending;
`ifdef TLC_PREEMPT_EN
  logic preempt = 0;
  logic [1:0] preempt_id = '0;
`endif
  int n_cmp = 0, n_bad = 0;

  tlc_phase_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .req(req),
`ifdef TLC_PREEMPT_EN
    .preempt(preempt), .preempt_id(preempt_id),
`endif
    .green_ticks(gt), .yel_ticks(yt), .allred_ticks(at),
    .lights(lights), .active_id(active_id), .phase(phase), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, ena, tick;
    logic [3:0] req;
    logic [1:0] ph, act;
    logic [3:0] pend;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1;
    cyc();
    tick = 0;
    cyc();
  endtask

  task automatic reset_dut(input logic [7:0] g, input logic [7:0] y, input logic [7:0] a);
    gt = g; yt = y; at = a; req = '0; ena = 1; tick = 0; rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  function automatic logic [11:0] lmodel(input logic [1:0] ph, input logic [1:0] act);
    logic [11:0] l;
    l = 12'b100_100_100_100;
    if (ph == 2'd0) l[act*3 +: 3] = 3'b001;
    if (ph == 2'd1) l[act*3 +: 3] = 3'b010;
    return l;
  endfunction

  initial begin
    int y_at, r_at, g_at, ngreen, nonred;
    logic [1:0] seq[3];
    logic [1:0] last_g;
    logic saw_red;
    logic [11:0] lk;
    // rst ena tick req -> phase active pending   (green=2 yel=1 allred=1)
    tbl[0]  = '{0, 1, 0, 4'b0000, 2'd0, 2'd0, 4'b0000};
    tbl[1]  = '{1, 1, 0, 4'b0100, 2'd0, 2'd0, 4'b0100};
    tbl[2]  = '{1, 1, 1, 4'b0000, 2'd0, 2'd0, 4'b0100};
    tbl[3]  = '{1, 1, 1, 4'b0000, 2'd1, 2'd0, 4'b0100};
    tbl[4]  = '{1, 0, 1, 4'b1000, 2'd1, 2'd0, 4'b1100};
    tbl[5]  = '{1, 1, 1, 4'b0000, 2'd2, 2'd0, 4'b1100};
    tbl[6]  = '{1, 1, 0, 4'b0000, 2'd2, 2'd0, 4'b1100};
    tbl[7]  = '{1, 1, 1, 4'b0100, 2'd0, 2'd2, 4'b1000};
    tbl[8]  = '{1, 1, 0, 4'b0100, 2'd0, 2'd2, 4'b1000};
    tbl[9]  = '{1, 1, 1, 4'b0000, 2'd0, 2'd2, 4'b1000};
    tbl[10] = '{1, 1, 1, 4'b0000, 2'd1, 2'd2, 4'b1000};
    tbl[11] = '{1, 1, 1, 4'b0000, 2'd2, 2'd2, 4'b1000};
    tbl[12] = '{1, 1, 1, 4'b0000, 2'd0, 2'd3, 4'b0000};
    tbl[13] = '{1, 1, 1, 4'b0000, 2'd0, 2'd3, 4'b0000};
    tbl[14] = '{1, 1, 1, 4'b0000, 2'd1, 2'd3, 4'b0000};
    tbl[15] = '{1, 1, 1, 4'b0000, 2'd2, 2'd3, 4'b0000};
    tbl[16] = '{1, 1, 1, 4'b0010, 2'd0, 2'd0, 4'b0010};
    tbl[17] = '{1, 1, 1, 4'b0000, 2'd0, 2'd0, 4'b0010};
    tbl[18] = '{0, 1, 0, 4'b0000, 2'd0, 2'd0, 4'b0000};
    gt = 8'd2; yt = 8'd1; at = 8'd1;
    cyc();
    for (int i = 0; i < 19; i++) begin
      rst_n = tbl[i].rst_n; ena = tbl[i].ena; tick = tbl[i].tick; req = tbl[i].req;
      cyc();
      chk($sformatf("vec%0d phase", i), phase, tbl[i].ph);
      chk($sformatf("vec%0d active", i), active_id, tbl[i].act);
      chk($sformatf("vec%0d pending", i), pending, tbl[i].pend);
      chk($sformatf("vec%0d lights", i), lights, lmodel(tbl[i].ph, tbl[i].act));
    end
    tick = 0; req = '0; rst_n = 1; ena = 1;

    // Idle parking on approach 0
    reset_dut(8'd10, 8'd3, 8'd1);
    chk("reset lights", lights, 12'b100_100_100_001);
    for (int t = 0; t < 50; t++) begin
      do_tick();
      if (t % 10 == 9) begin
        chk("idle lights", lights, 12'b100_100_100_001);
        chk("idle phase", phase, 2'd0);
        chk("idle active", active_id, 2'd0);
      end
    end

    // Single request on approach 2 with 10/3/1 timing
    reset_dut(8'd10, 8'd3, 8'd1);
    y_at = -1; r_at = -1; g_at = -1;
    for (int t = 1; t <= 40 && g_at < 0; t++) begin
      if (t == 2) req = 4'b0100;
      do_tick();
      req = '0;
      if (t == 2) chk("req2 latched", pending, 4'b0100);
      if (phase == 2'd1 && y_at < 0) y_at = t;
      if (phase == 2'd2 && r_at < 0) r_at = t;
      if (phase == 2'd0 && active_id == 2'd2) begin
        g_at = t;
        chk("appr2 green lights", lights, 12'b100_001_100_100);
        chk("appr2 pending cleared", pending, 4'b0000);
      end
    end
    chk("yellow tick", y_at, 10);
    chk("allred tick", r_at, 13);
    chk("green2 tick", g_at, 14);

    // Requests 1 and 3 together: served 1, 3, then back home
    reset_dut(8'd2, 8'd1, 8'd1);
    req = 4'b1010;
    cyc();
    req = '0;
    ngreen = 0; last_g = 2'd0; saw_red = 0;
    for (int t = 0; t < 40 && ngreen < 3; t++) begin
      do_tick();
      nonred = 0;
      for (int k = 0; k < 4; k++) if (lights[3*k +: 3] != 3'b100) nonred++;
      chk("single non-red", nonred <= 1, 1);
      if (phase == 2'd2) saw_red = 1;
      if (phase == 2'd0 && active_id != last_g) begin
        chk("allred gap before green", saw_red, 1);
        seq[ngreen] = active_id;
        ngreen++;
        last_g = active_id;
        saw_red = 0;
      end
    end
    chk("green count", ngreen, 3);
    chk("order first", seq[0], 2'd1);
    chk("order second", seq[1], 2'd3);
    chk("order third", seq[2], 2'd0);

    // Enable freeze mid-yellow
    reset_dut(8'd2, 8'd3, 8'd1);
    req = 4'b0010;
    cyc();
    req = '0;
    do_tick();
    do_tick();
    chk("freeze enters yellow", phase, 2'd1);
    do_tick();
    lk = lights;
    ena = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) req = 4'b1000;
      do_tick();
      req = '0;
    end
    chk("frozen phase", phase, 2'd1);
    chk("frozen lights", lights, lk);
    chk("frozen lights value", lights, 12'b100_100_100_010);
    chk("frozen latch", pending, 4'b1010);
    ena = 1;
    do_tick();
    chk("resume yellow", phase, 2'd1);
    do_tick();
    chk("resume allred", phase, 2'd2);
    do_tick();
    chk("resume green1", {phase, active_id}, {2'd0, 2'd1});

    // Zero green duration behaves as one tick, then reset during ALLRED
    reset_dut(8'd0, 8'd1, 8'd1);
    req = 4'b0100;
    cyc();
    req = '0;
    chk("green0 before tick", phase, 2'd0);
    do_tick();
    chk("green0 one tick", phase, 2'd1);
    do_tick();
    chk("reach allred", phase, 2'd2);
    req = 4'b1000;
    cyc();
    req = '0;
    chk("pending before rst", pending, 4'b1100);
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("rst phase", phase, 2'd0);
    chk("rst active", active_id, 2'd0);
    chk("rst pending", pending, 4'b0000);
    chk("rst lights", lights, 12'b100_100_100_001);

`ifdef TLC_PREEMPT_EN
    reset_dut(8'd10, 8'd1, 8'd1);
    do_tick();
    preempt = 1; preempt_id = 2'd3;
    cyc();
    chk("preempt yellow", phase, 2'd1);
    do_tick();
    do_tick();
    chk("preempt green3", {phase, active_id}, {2'd0, 2'd3});
    for (int i = 0; i < 20; i++) begin
      if (i == 2) req = 4'b0001;
      do_tick();
      req = '0;
    end
    chk("preempt held", {phase, active_id}, {2'd0, 2'd3});
    preempt = 0;
    cyc();
    chk("preempt release", phase, 2'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
